archon_override_arbiter: RTL
============================

// Module: archon_override_arbiter
// PURPOSE
//   Arbitrates the ARCHON pipeline-control requesters into one stall/flush/lock command stream.
//   Requesters: quantum override, analog lock/flush overrides, external entropy, ML action, internal entropy.
//   Sits between the override/entropy inputs of archon_top and the pipeline control.
//   Enforces priority, minimum hold times, timed flushes, a sticky lock with a release handshake,
//   and post-event recovery stalls.
// PARAMETERS
//   FLUSH_CYCLES        3          cycles pipe_flush is held per flush event (>=1)
//   MIN_STALL           2          minimum cycles in STALL once entered (>=1)
//   RECOVER_CYCLES      2          stall cycles after a flush or lock release (>=1)
//   LOCK_RELEASE_CYCLES 4          consecutive lock-free cycles required to leave LOCK (>=1)
//   INT_STALL_THRESH    8'd128     internal_entropy_score >= this requests a stall
//   EXT_FLUSH_THRESH    16'd50000  external_entropy_in >= this requests a flush
// PORTS
//   clk                     in   1   clock; all logic on posedge
//   rst                     in   1   synchronous reset, active-high
//   quantum_override_signal in   1   lock request, highest priority
//   analog_lock_override    in   1   lock request
//   analog_flush_override   in   1   flush request
//   ml_predicted_action     in   2   00 normal, 01 stall, 10 flush, 11 reserved (ignored)
//   internal_entropy_score  in   8   internal entropy
//   external_entropy_in     in   16  external entropy
//   pipe_stall              out  1   stall pipeline
//   pipe_flush              out  1   flush pipeline
//   sys_lock                out  1   system lock
//   arb_state               out  3   0 IDLE, 1 STALL, 2 FLUSH, 3 LOCK, 4 RECOVER
//   grant_src               out  3   winning source: 0 none, 1 quantum, 2 a_lock, 3 a_flush,
//                                    4 ext_entropy, 5 ml_flush, 6 int_entropy, 7 ml_stall
//   flush_event_count       out  8   FLUSH entries, saturates at 255
//   lock_event_count        out  8   LOCK entries, saturates at 255
//   entropy_log             out  8   internal_entropy_score latched on every arb_state change
// BEHAVIOUR
//   - Reset: arb_state=IDLE; all outputs 0; all internal counters 0. Reset mid-event aborts the event
//     immediately; there is no recovery phase.
//   - Request classes are evaluated combinationally every cycle, in this priority order:
//       LOCK  = quantum | a_lock
//       FLUSH = a_flush | ext>=EXT_FLUSH_THRESH | ml==10
//       STALL = int>=INT_STALL_THRESH | ml==01
//       NONE  otherwise
//     grant_src = the highest-priority active source, in code order 1..7.
//   - State and all outputs are registered. A request sampled at edge N is visible on the outputs after edge N.
//   - Decode: pipe_stall = STALL|LOCK|RECOVER; pipe_flush = FLUSH; sys_lock = LOCK.
//     pipe_stall and pipe_flush are never both 1.
//   - Hold counter: load N-1 on state entry; decrement each cycle in the state; expiry means cnt==0 at the edge.
//   - IDLE: LOCK->LOCK; FLUSH->FLUSH (load FLUSH_CYCLES); STALL->STALL (load MIN_STALL); NONE stays.
//   - STALL: LOCK or FLUSH request preempts at once. Exit to IDLE only when the counter has expired
//     and no STALL request is active. A held request keeps STALL indefinitely.
//   - FLUSH: lasts exactly FLUSH_CYCLES unless a LOCK request preempts. Other requests are ignored.
//     On expiry go to RECOVER (load RECOVER_CYCLES). A flush request still active after RECOVER
//     starts a new FLUSH from IDLE.
//   - LOCK: release counter clears on any cycle with a LOCK request and increments otherwise.
//     When it reaches LOCK_RELEASE_CYCLES, go to RECOVER. FLUSH and STALL requests are ignored.
//   - RECOVER: a LOCK request preempts. Otherwise go to IDLE after RECOVER_CYCLES.
//     Pending requests are re-evaluated from IDLE on the next cycle.
//   - grant_src updates on entry to STALL, FLUSH or LOCK, and on re-entry via preemption.
//     It holds through RECOVER and clears to 0 on entry to IDLE.
//   - Event counters increment once per entry into FLUSH or LOCK. They saturate at 255 and never wrap.
//   - entropy_log updates only on the edge where arb_state changes.
// TESTING
//   1 Reset: rst=1 for 2 cycles with all requests high -> all outputs 0, arb_state=0; release -> LOCK next edge.
//   2 ml=01 for 1 cycle -> STALL for exactly 2 cycles, grant_src=7, then IDLE with grant_src=0.
//   3 ext=60000 for 1 cycle -> pipe_flush high for 3 cycles, then pipe_stall for 2 cycles (RECOVER),
//     then IDLE; flush_event_count=1.
//   4 int=200 and a_flush=1 in the same cycle -> FLUSH with grant_src=3. Quantum asserted in FLUSH
//     cycle 2 -> LOCK next edge with grant_src=1, lock_event_count=1.
//   5 Quantum held 10 cycles, then dropped -> LOCK persists 4 more cycles, then 2 RECOVER cycles, then IDLE.
//     Quantum re-pulsed at lock-free cycle 3 -> the release count restarts.
//   6 Produce 260 flush events -> flush_event_count saturates at 255. Check entropy_log equals int
//     at every arb_state change.

Source files
------------

// File: rtl/archon_override_arbiter.sv
// Priority arbiter folding the ARCHON lock/flush/stall requesters into one registered
// pipeline-control command, with hold timers, sticky lock release and recovery stalls.
module archon_override_arbiter #(
  parameter int unsigned FLUSH_CYCLES        = 3,
  parameter int unsigned MIN_STALL           = 2,
  parameter int unsigned RECOVER_CYCLES      = 2,
  parameter int unsigned LOCK_RELEASE_CYCLES = 4,
  parameter logic [7:0]  INT_STALL_THRESH    = 8'd128,
  parameter logic [15:0] EXT_FLUSH_THRESH    = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        quantum_override_signal,
  input  logic        analog_lock_override,
  input  logic        analog_flush_override,
  input  logic [1:0]  ml_predicted_action,
  input  logic [7:0]  internal_entropy_score,
  input  logic [15:0] external_entropy_in,
  output logic        pipe_stall,
  output logic        pipe_flush,
  output logic        sys_lock,
  output logic [2:0]  arb_state,
  output logic [2:0]  grant_src,
  output logic [7:0]  flush_event_count,
  output logic [7:0]  lock_event_count,
  output logic [7:0]  entropy_log
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] FlushLoad   = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] StallLoad   = CntW'(MIN_STALL - 1);
  localparam logic [CntW-1:0] RecoverLoad = CntW'(RECOVER_CYCLES - 1);
  localparam logic [CntW-1:0] RelLast     = CntW'(LOCK_RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStall   = 3'd1,
    StFlush   = 3'd2,
    StLock    = 3'd3,
    StRecover = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] rel_q, rel_d;
  logic [2:0]      grant_q, grant_d;
  logic [7:0]      flush_cnt_q, flush_cnt_d;
  logic [7:0]      lock_cnt_q, lock_cnt_d;
  logic [7:0]      elog_q;

  logic       lock_req, flush_req, stall_req;
  logic [2:0] src;

  always_comb begin
    lock_req  = quantum_override_signal | analog_lock_override;
    flush_req = analog_flush_override | (external_entropy_in >= EXT_FLUSH_THRESH) |
                (ml_predicted_action == 2'b10);
    stall_req = (internal_entropy_score >= INT_STALL_THRESH) | (ml_predicted_action == 2'b01);

    src = 3'd0;
    if (quantum_override_signal)                        src = 3'd1;
    else if (analog_lock_override)                      src = 3'd2;
    else if (analog_flush_override)                     src = 3'd3;
    else if (external_entropy_in >= EXT_FLUSH_THRESH)   src = 3'd4;
    else if (ml_predicted_action == 2'b10)              src = 3'd5;
    else if (internal_entropy_score >= INT_STALL_THRESH) src = 3'd6;
    else if (ml_predicted_action == 2'b01)              src = 3'd7;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    grant_d     = grant_q;
    flush_cnt_d = flush_cnt_q;
    lock_cnt_d  = lock_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (lock_req)       state_d = StLock;
        else if (flush_req) state_d = StFlush;
        else if (stall_req) state_d = StStall;
      end
      StStall: begin
        if (lock_req)                             state_d = StLock;
        else if (flush_req)                       state_d = StFlush;
        else if (cnt_q == '0 && !stall_req)       state_d = StIdle;
        else if (cnt_q != '0)                     cnt_d   = cnt_q - CntW'(1);
      end
      StFlush: begin
        if (lock_req)          state_d = StLock;
        else if (cnt_q == '0)  state_d = StRecover;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StLock: begin
        // Any lock request restarts the lock-free run.
        if (lock_req)              rel_d   = '0;
        else if (rel_q == RelLast) state_d = StRecover;
        else                       rel_d   = rel_q + CntW'(1);
      end
      StRecover: begin
        if (lock_req)          state_d = StLock;
        else if (cnt_q == '0)  state_d = StIdle;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        StLock: begin
          rel_d   = '0;
          grant_d = src;
          if (lock_cnt_q != 8'hff) lock_cnt_d = lock_cnt_q + 8'd1;
        end
        StFlush: begin
          cnt_d   = FlushLoad;
          grant_d = src;
          if (flush_cnt_q != 8'hff) flush_cnt_d = flush_cnt_q + 8'd1;
        end
        StStall: begin
          cnt_d   = StallLoad;
          grant_d = src;
        end
        StRecover: cnt_d   = RecoverLoad;
        StIdle:    grant_d = 3'd0;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rel_q       <= '0;
      grant_q     <= 3'd0;
      flush_cnt_q <= 8'd0;
      lock_cnt_q  <= 8'd0;
      elog_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      grant_q     <= grant_d;
      flush_cnt_q <= flush_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      if (state_d != state_q) elog_q <= internal_entropy_score;
    end
  end

  assign arb_state         = state_q;
  assign pipe_stall        = (state_q == StStall) | (state_q == StLock) | (state_q == StRecover);
  assign pipe_flush        = (state_q == StFlush);
  assign sys_lock          = (state_q == StLock);
  assign grant_src         = grant_q;
  assign flush_event_count = flush_cnt_q;
  assign lock_event_count  = lock_cnt_q;
  assign entropy_log       = elog_q;

endmodule
